// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer.
// This package holds the FSM states, the reset and exception vectors, and the next-PC source codes.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0180;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SRC_SEQ = 3'd0,
    SRC_BR  = 3'd1,
    SRC_J   = 3'd2,
    SRC_JR  = 3'd3,
    SRC_EXC = 3'd4
  } src_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC selection: jr > jump > branch > pc+4, trapping misaligned targets.
module next_pc_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] candidate;
  src_t        src;

  always_comb begin
    candidate = pc + 32'd4;
    src       = SRC_SEQ;
    if (jr) begin
      candidate = jr_target;
      src       = SRC_JR;
    end else if (jump) begin
      candidate = jump_target;
      src       = SRC_J;
    end else if (branch_taken) begin
      candidate = branch_target;
      src       = SRC_BR;
    end
    // A misaligned candidate overrides whichever source produced it.
    if (is_misaligned(candidate)) begin
      src = SRC_EXC;
    end
  end

  always_comb begin
    next_pc  = candidate;
    misalign = 1'b0;
    case (src)
      SRC_EXC: begin
        next_pc  = EXC_VECTOR;
        misalign = 1'b1;
      end
      default: next_pc = candidate;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch/execute FSM.
// Each instruction is fetched through a req/ack handshake and held for one execute cycle.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        exc,
  output logic        halted
);

  state_t      state, state_next;
  logic [31:0] pc_next, instr_next;
  logic        exc_next;
  logic [31:0] sel_pc;
  logic        sel_misalign;

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (sel_pc),
    .misalign      (sel_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= RESET_VECTOR;
      instr <= '0;
      exc   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
      exc   <= exc_next;
    end
  end

  // Control inputs only matter in S_EXEC, and an ack seen outside S_FETCH is dropped.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    exc_next   = 1'b0;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (halt) begin
          state_next = S_HALT;
        end else begin
          pc_next    = sel_pc;
          exc_next   = sel_misalign;
          state_next = S_FETCH;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign pc_plus4    = pc + 32'd4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, wait states, priority, traps, halt and reset.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt;
  logic        exc;
  logic        halted;

  int          pass_count = 0;
  int          fail_count = 0;
  int          check_count = 0;
  logic [31:0] last_instr = 32'h0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .halt          (halt),
    .exc           (exc),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Starts at a negedge inside S_FETCH at addr; ends at the negedge after the execute cycle.
  task automatic applyStimulus(input logic [31:0] addr, input int waits, input logic [31:0] data,
                               input logic exp_exc,
                               input logic c_jr, input logic [31:0] t_jr,
                               input logic c_j, input logic [31:0] t_j,
                               input logic c_br, input logic [31:0] t_br,
                               input logic c_halt);
    checkOutput("fetch_req", {31'b0, imem_req}, 32'd1);
    checkOutput("fetch_addr", imem_addr, addr);
    checkOutput("fetch_pc_plus4", pc_plus4, addr + 32'd4);
    checkOutput("fetch_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("fetch_exc", {31'b0, exc}, {31'b0, exp_exc});
    for (int i = 0; i < waits; i++) begin
      imem_ack    = 1'b0;
      jump        = 1'b1;
      jump_target = 32'h0000_0400;
      step();
      checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, addr);
      checkOutput("wait_instr", instr, last_instr);
    end
    jump       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    checkOutput("exec_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("exec_instr", instr, data);
    checkOutput("exec_req", {31'b0, imem_req}, 32'd0);
    checkOutput("exec_exc", {31'b0, exc}, 32'd0);
    jr            = c_jr;
    jr_target     = t_jr;
    jump          = c_j;
    jump_target   = t_j;
    branch_taken  = c_br;
    branch_target = t_br;
    halt          = c_halt;
    step();
    jr           = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
    last_instr   = data;
  endtask

  initial begin
    reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    jr            = 1'b0;
    jr_target     = 32'h0;
    halt          = 1'b0;

    step();
    step();
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_exc", {31'b0, exc}, 32'd0);
    checkOutput("rst_halted", {31'b0, halted}, 32'd0);

    reset = 1'b0;
    checkOutput("idle_req", {31'b0, imem_req}, 32'd0);
    step();

    // Zero-wait sequential run.
    applyStimulus(32'h00, 0, 32'hA000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h04, 0, 32'hA000_0004, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h08, 0, 32'hA000_0008, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h0C, 0, 32'hA000_000C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Three wait cycles at 0x10, with a stray jump held during the wait.
    applyStimulus(32'h10, 3, 32'hB000_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h14, 0, 32'hA000_0014, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h18, 0, 32'hA000_0018, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h1C, 0, 32'hA000_001C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Priority: jr beats jump and branch, then jump beats branch.
    applyStimulus(32'h20, 0, 32'hC000_0020, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    applyStimulus(32'h100, 0, 32'hC000_0100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);

    // Misaligned branch traps to the exception vector.
    applyStimulus(32'h200, 0, 32'hC000_0200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h42, 1'b0);
    applyStimulus(32'h180, 0, 32'hE000_0180, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // pc+4 wraps at the top of the address space.
    applyStimulus(32'h184, 0, 32'hE000_0184, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'hFFFF_FFFC, 0, 32'hF000_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h00, 0, 32'hA000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);

    // Halt wins over a simultaneous jump and leaves pc unchanged.
    applyStimulus(32'h30, 0, 32'hD000_0030, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    checkOutput("halt_halted", {31'b0, halted}, 32'd1);
    checkOutput("halt_req", {31'b0, imem_req}, 32'd0);
    checkOutput("halt_pc", pc, 32'h30);
    jump        = 1'b1;
    jump_target = 32'h600;
    imem_ack    = 1'b1;
    step();
    step();
    jump     = 1'b0;
    imem_ack = 1'b0;
    checkOutput("halt_hold", {31'b0, halted}, 32'd1);
    checkOutput("halt_hold_req", {31'b0, imem_req}, 32'd0);
    checkOutput("halt_hold_pc", pc, 32'h30);
    checkOutput("halt_hold_instr", instr, 32'hD000_0030);

    // Reset out of halt restarts at the reset vector.
    reset = 1'b1;
    step();
    checkOutput("rst2_pc", pc, 32'h0);
    checkOutput("rst2_halted", {31'b0, halted}, 32'd0);
    checkOutput("rst2_instr", instr, 32'h0);
    reset = 1'b0;
    step();
    last_instr = 32'h0;
    applyStimulus(32'h00, 0, 32'h1111_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset while a fetch waits for ack, then an ack pulse during S_IDLE.
    checkOutput("midfetch_req", {31'b0, imem_req}, 32'd1);
    checkOutput("midfetch_addr", imem_addr, 32'h04);
    reset = 1'b1;
    step();
    checkOutput("rst3_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst3_instr", instr, 32'h0);
    checkOutput("rst3_pc", pc, 32'h0);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    checkOutput("idle_ack_instr", instr, 32'h0);
    checkOutput("restart_valid", {31'b0, instr_valid}, 32'd0);
    last_instr = 32'h0;
    applyStimulus(32'h00, 0, 32'h2222_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("final_addr", imem_addr, 32'h04);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
